count_snapshot: RTL

Downstream consumer of the free-running counter: on each `trig` pulse it captures the current counter value together with the modular difference from the previous accepted capture, and buffers both in a small FIFO drained through a valid/ready interface. It converts a raw count into timestamped interval records, for example for period measurement of events in cocotb benches. Captures arriving while the FIFO is full are dropped, and the loss is reported through a sticky overflow flag and a saturating drop counter.

---
 rtl/count_snapshot_if.sv | 24 ++
 rtl/count_snapshot.sv | 107 ++++++++++
 2 files changed

// File: rtl/count_snapshot_if.sv
// Valid/ready record stream carrying a captured counter value and its delta
// from the previous accepted capture.
interface count_snapshot_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic                     m_valid;
    logic                     m_ready;
    logic [COUNTER_WIDTH-1:0] m_cnt;
    logic [COUNTER_WIDTH-1:0] m_delta;

    modport master (
        output m_valid,
        output m_cnt,
        output m_delta,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_cnt,
        input  m_delta,
        output m_ready
    );
endinterface

// File: rtl/count_snapshot.sv
// Captures {cnt, cnt - previous capture} on each trig into a small FIFO drained
// over valid/ready; captures hitting a full FIFO are dropped and counted.
module count_snapshot #(
    parameter int COUNTER_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] cnt,
    input  logic                     trig,
    input  logic                     clr_ovf,
    count_snapshot_if.master         m,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]            wr_ptr_reg;
    logic [AW-1:0]            rd_ptr_reg;
    logic [LW-1:0]            level_reg;
    logic [LW-1:0]            level_next;
    logic [COUNTER_WIDTH-1:0] prev_reg;
    logic                     overflow_reg;
    logic                     overflow_next;
    logic [7:0]               drop_cnt_reg;
    logic [7:0]               drop_cnt_next;

    logic [COUNTER_WIDTH-1:0] cnt_mem   [DEPTH];
    logic [COUNTER_WIDTH-1:0] delta_mem [DEPTH];

    logic                     full;
    logic                     pop;
    logic                     push;
    logic                     drop;
    logic [COUNTER_WIDTH-1:0] delta;

    assign full  = (level_reg == LW'(DEPTH));
    assign pop   = m.m_valid && m.m_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push  = trig && (!full || pop);
    assign drop  = trig && full && !pop;
    assign delta = cnt - prev_reg;

    assign m.m_valid = (level_reg != '0);
    assign m.m_cnt   = cnt_mem[rd_ptr_reg];
    assign m.m_delta = delta_mem[rd_ptr_reg];

    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // A drop coinciding with clr_ovf restarts the tally at one rather than zero.
    always_comb begin
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            overflow_next = 1'b1;
            if (clr_ovf)
                drop_cnt_next = 8'd1;
            else if (drop_cnt_reg != 8'hFF)
                drop_cnt_next = drop_cnt_reg + 8'd1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
            drop_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            prev_reg     <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            level_reg    <= level_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                prev_reg   <= cnt;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
    end

    // Storage needs no reset: entries are only visible once level covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            cnt_mem[wr_ptr_reg]   <= cnt;
            delta_mem[wr_ptr_reg] <= delta;
        end
    end
endmodule
